// File: rtl/id_ex_pipe_reg.sv
// ID/EX pipeline register with stall, flush, load-use bubble insertion and a
// saturating bubble counter; hazard_stall tells IF/ID to hold during a bubble.
`default_nettype none

module id_ex_pipe_reg #(
  parameter int DATA_W  = 32,
  parameter int REG_AW  = 5,
  parameter int ALUOP_W = 4,
  parameter int CNT_W   = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  input  logic               stall,
  input  logic               flush,
  input  logic               reg_write,
  input  logic               mem_to_reg,
  input  logic               mem_write,
  input  logic               mem_read,
  input  logic               alu_src,
  input  logic               reg_dst,
  input  logic [ALUOP_W-1:0] alu_op,
  input  logic [DATA_W-1:0]  pc_plus4,
  input  logic [DATA_W-1:0]  rd1,
  input  logic [DATA_W-1:0]  rd2,
  input  logic [DATA_W-1:0]  sext,
  input  logic [REG_AW-1:0]  rs,
  input  logic [REG_AW-1:0]  rt,
  input  logic [REG_AW-1:0]  rd,
  output logic               ex_valid,
  output logic               ex_reg_write,
  output logic               ex_mem_to_reg,
  output logic               ex_mem_write,
  output logic               ex_mem_read,
  output logic               ex_alu_src,
  output logic               ex_reg_dst,
  output logic [ALUOP_W-1:0] ex_alu_op,
  output logic [DATA_W-1:0]  ex_pc_plus4,
  output logic [DATA_W-1:0]  ex_rd1,
  output logic [DATA_W-1:0]  ex_rd2,
  output logic [DATA_W-1:0]  ex_sext,
  output logic [REG_AW-1:0]  ex_rs,
  output logic [REG_AW-1:0]  ex_rt,
  output logic [REG_AW-1:0]  ex_rd,
  output logic               hazard_stall,
  output logic [CNT_W-1:0]   bubble_cnt
);

  localparam int CTRL_W = 6 + ALUOP_W;
  localparam int DBUS_W = 4 * DATA_W + 3 * REG_AW;
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic              valid_q, valid_d;
  logic [CTRL_W-1:0] ctrl_q, ctrl_d;
  logic [DBUS_W-1:0] data_q, data_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic [CTRL_W-1:0] ctrl_in;
  logic [DBUS_W-1:0] data_in;
  logic              hazard;

  assign ctrl_in = {reg_write, mem_to_reg, mem_write, mem_read, alu_src, reg_dst, alu_op};
  assign data_in = {pc_plus4, rd1, rd2, sext, rs, rt, rd};

  assign ex_valid = valid_q;
  assign {ex_reg_write, ex_mem_to_reg, ex_mem_write, ex_mem_read,
          ex_alu_src, ex_reg_dst, ex_alu_op} = ctrl_q;
  assign {ex_pc_plus4, ex_rd1, ex_rd2, ex_sext, ex_rs, ex_rt, ex_rd} = data_q;
  assign bubble_cnt = cnt_q;

  // $zero is never a real load destination, so it cannot create a dependency.
  assign hazard = in_valid & valid_q & ex_mem_read & (ex_rt != '0) &
                  ((ex_rt == rs) | (ex_rt == rt));
  assign hazard_stall = hazard & ~flush;

  always_comb begin
    valid_d = valid_q;
    ctrl_d  = ctrl_q;
    data_d  = data_q;
    cnt_d   = cnt_q;
    if (flush) begin
      valid_d = 1'b0;
      ctrl_d  = '0;
    end else if (stall) begin
      valid_d = valid_q;
    end else if (hazard) begin
      valid_d = 1'b0;
      ctrl_d  = '0;
      data_d  = data_in;
      if (cnt_q != CNT_MAX) begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end else begin
      valid_d = in_valid;
      ctrl_d  = in_valid ? ctrl_in : '0;
      data_d  = data_in;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      ctrl_q  <= '0;
      data_q  <= '0;
      cnt_q   <= '0;
    end else begin
      valid_q <= valid_d;
      ctrl_q  <= ctrl_d;
      data_q  <= data_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_id_ex_pipe_reg.sv
// Scoreboard bench for id_ex_pipe_reg; a 2-bit bubble counter makes saturation reachable.
`default_nettype none

module tb_id_ex_pipe_reg;

  typedef struct packed {
    logic        valid;
    logic [9:0]  ctrl;
    logic [31:0] pc;
    logic [31:0] d1;
    logic [31:0] d2;
    logic [31:0] sx;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [1:0]  cnt;
  } exp_t;

  localparam logic [9:0] C_LOAD = 10'h360;  // reg_write, mem_to_reg, mem_read, alu_src
  localparam logic [9:0] C_ADD  = 10'h212;  // reg_write, reg_dst, alu_op 2

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        iv = 1'b0, fl = 1'b0, st = 1'b0;
  logic [9:0]  ctl = '0;
  logic [31:0] pc = '0, d1 = '0, d2 = '0, sx = '0;
  logic [4:0]  rs_i = '0, rt_i = '0, rd_i = '0;

  logic        ex_valid, ex_reg_write, ex_mem_to_reg, ex_mem_write, ex_mem_read;
  logic        ex_alu_src, ex_reg_dst, hazard_stall;
  logic [3:0]  ex_alu_op;
  logic [31:0] ex_pc_plus4, ex_rd1, ex_rd2, ex_sext;
  logic [4:0]  ex_rs, ex_rt, ex_rd;
  logic [1:0]  bubble_cnt;
  exp_t        obs;

  int   checks = 0;
  int   failures = 0;
  exp_t sb[$];
  exp_t e, prev;

  id_ex_pipe_reg #(.DATA_W(32), .REG_AW(5), .ALUOP_W(4), .CNT_W(2)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(iv), .stall(st), .flush(fl),
    .reg_write(ctl[9]), .mem_to_reg(ctl[8]), .mem_write(ctl[7]), .mem_read(ctl[6]),
    .alu_src(ctl[5]), .reg_dst(ctl[4]), .alu_op(ctl[3:0]),
    .pc_plus4(pc), .rd1(d1), .rd2(d2), .sext(sx), .rs(rs_i), .rt(rt_i), .rd(rd_i),
    .ex_valid(ex_valid), .ex_reg_write(ex_reg_write), .ex_mem_to_reg(ex_mem_to_reg),
    .ex_mem_write(ex_mem_write), .ex_mem_read(ex_mem_read), .ex_alu_src(ex_alu_src),
    .ex_reg_dst(ex_reg_dst), .ex_alu_op(ex_alu_op), .ex_pc_plus4(ex_pc_plus4),
    .ex_rd1(ex_rd1), .ex_rd2(ex_rd2), .ex_sext(ex_sext), .ex_rs(ex_rs), .ex_rt(ex_rt),
    .ex_rd(ex_rd), .hazard_stall(hazard_stall), .bubble_cnt(bubble_cnt)
  );

  assign obs = {ex_valid, ex_reg_write, ex_mem_to_reg, ex_mem_write, ex_mem_read,
                ex_alu_src, ex_reg_dst, ex_alu_op, ex_pc_plus4, ex_rd1, ex_rd2,
                ex_sext, ex_rs, ex_rt, ex_rd, bubble_cnt};

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic exp_t mk(input logic v, input logic [9:0] c, input logic [4:0] s,
                              input logic [4:0] t, input logic [4:0] d,
                              input logic [31:0] b, input logic [1:0] n);
    mk = {v, c, b, b ^ 32'hA5A5_5A5A, b + 32'd1, ~b, s, t, d, n};
  endfunction

  task automatic drive(input logic v, input logic [9:0] c, input logic [4:0] s,
                       input logic [4:0] t, input logic [4:0] d, input logic [31:0] b);
    iv = v; ctl = c; rs_i = s; rt_i = t; rd_i = d;
    pc = b; d1 = b ^ 32'hA5A5_5A5A; d2 = b + 32'd1; sx = ~b;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst_n = 1'b1;
    drive(1'b1, 10'h3FF, 5'd1, 5'd7, 5'd9, 32'hDEAD_BEEF);
    sb.push_back(mk(1'b1, 10'h3FF, 5'd1, 5'd7, 5'd9, 32'hDEAD_BEEF, 2'd0));
    @(posedge clk); #1;
    e = sb.pop_front();
    checks++;
    if (obs !== e) begin
      failures++; $display("FAIL reset_preload obs=%h exp=%h", obs, e);
    end
    @(negedge clk); #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (obs !== '0) begin
      failures++; $display("FAIL reset_async obs=%h exp=0", obs);
    end
    checks++;
    if (hazard_stall !== 1'b0) begin
      failures++; $display("FAIL reset_hazard obs=%b exp=0", hazard_stall);
    end
    @(negedge clk);
    rst_n = 1'b1;
    prev = '0;
  endtask

  task automatic test_transfer();
    @(negedge clk);
    drive(1'b1, 10'h202, 5'd3, 5'd4, 5'd8, 32'h1234_5678);
    d1 = 32'h1234_5678;
    sb.push_back(mk(1'b1, 10'h202, 5'd3, 5'd4, 5'd8, 32'h1234_5678, 2'd0));
    @(posedge clk); #1;
    e = sb.pop_front();
    e.d1 = 32'h1234_5678;
    checks++;
    if (obs !== e) begin
      failures++; $display("FAIL transfer_valid obs=%h exp=%h", obs, e);
    end
    @(negedge clk);
    drive(1'b0, 10'h200, 5'd10, 5'd11, 5'd12, 32'h0000_1000);
    sb.push_back(mk(1'b0, 10'h000, 5'd10, 5'd11, 5'd12, 32'h0000_1000, 2'd0));
    @(posedge clk); #1;
    e = sb.pop_front();
    checks++;
    if (obs !== e) begin
      failures++; $display("FAIL transfer_invalid obs=%h exp=%h", obs, e);
    end
  endtask

  task automatic test_load_use();
    @(negedge clk);
    drive(1'b1, C_LOAD, 5'd1, 5'd5, 5'd0, 32'h0000_2000);
    sb.push_back(mk(1'b1, C_LOAD, 5'd1, 5'd5, 5'd0, 32'h0000_2000, 2'd0));
    @(posedge clk); #1;
    e = sb.pop_front();
    checks++;
    if (obs !== e) begin
      failures++; $display("FAIL loaduse_load obs=%h exp=%h", obs, e);
    end
    @(negedge clk);
    drive(1'b1, C_ADD, 5'd5, 5'd6, 5'd7, 32'h0000_2004);
    #1;
    checks++;
    if (hazard_stall !== 1'b1) begin
      failures++; $display("FAIL loaduse_hazard obs=%b exp=1", hazard_stall);
    end
    sb.push_back(mk(1'b0, 10'h000, 5'd5, 5'd6, 5'd7, 32'h0000_2004, 2'd1));
    @(posedge clk); #1;
    e = sb.pop_front();
    checks++;
    if (obs !== e) begin
      failures++; $display("FAIL loaduse_bubble obs=%h exp=%h", obs, e);
    end
    checks++;
    if (hazard_stall !== 1'b0) begin
      failures++; $display("FAIL loaduse_hazard_drop obs=%b exp=0", hazard_stall);
    end
    sb.push_back(mk(1'b1, C_ADD, 5'd5, 5'd6, 5'd7, 32'h0000_2004, 2'd1));
    @(posedge clk); #1;
    e = sb.pop_front();
    checks++;
    if (obs !== e) begin
      failures++; $display("FAIL loaduse_issue obs=%h exp=%h", obs, e);
    end
  endtask

  task automatic test_zero_reg();
    @(negedge clk);
    drive(1'b1, C_LOAD, 5'd1, 5'd0, 5'd0, 32'h0000_3000);
    sb.push_back(mk(1'b1, C_LOAD, 5'd1, 5'd0, 5'd0, 32'h0000_3000, 2'd1));
    @(posedge clk); #1;
    e = sb.pop_front();
    checks++;
    if (obs !== e) begin
      failures++; $display("FAIL zero_load obs=%h exp=%h", obs, e);
    end
    @(negedge clk);
    drive(1'b1, C_ADD, 5'd0, 5'd0, 5'd3, 32'h0000_3004);
    #1;
    checks++;
    if (hazard_stall !== 1'b0) begin
      failures++; $display("FAIL zero_hazard obs=%b exp=0", hazard_stall);
    end
    sb.push_back(mk(1'b1, C_ADD, 5'd0, 5'd0, 5'd3, 32'h0000_3004, 2'd1));
    @(posedge clk); #1;
    e = sb.pop_front();
    checks++;
    if (obs !== e) begin
      failures++; $display("FAIL zero_issue obs=%h exp=%h", obs, e);
    end
  endtask

  task automatic test_priority();
    @(negedge clk);
    drive(1'b1, C_LOAD, 5'd2, 5'd9, 5'd0, 32'h0000_4000);
    sb.push_back(mk(1'b1, C_LOAD, 5'd2, 5'd9, 5'd0, 32'h0000_4000, 2'd1));
    @(posedge clk); #1;
    e = sb.pop_front();
    prev = e;
    checks++;
    if (obs !== e) begin
      failures++; $display("FAIL prio_load1 obs=%h exp=%h", obs, e);
    end
    // Flush beats the hazard: EX data holds, controls clear, no count.
    @(negedge clk);
    drive(1'b1, C_ADD, 5'd9, 5'd3, 5'd4, 32'h0000_4004);
    fl = 1'b1;
    #1;
    checks++;
    if (hazard_stall !== 1'b0) begin
      failures++; $display("FAIL prio_flush_hazard obs=%b exp=0", hazard_stall);
    end
    e = prev; e.valid = 1'b0; e.ctrl = '0;
    sb.push_back(e);
    @(posedge clk); #1;
    e = sb.pop_front();
    checks++;
    if (obs !== e) begin
      failures++; $display("FAIL prio_flush obs=%h exp=%h", obs, e);
    end
    @(negedge clk);
    fl = 1'b0;
    drive(1'b1, C_LOAD, 5'd2, 5'd9, 5'd0, 32'h0000_4010);
    sb.push_back(mk(1'b1, C_LOAD, 5'd2, 5'd9, 5'd0, 32'h0000_4010, 2'd1));
    @(posedge clk); #1;
    e = sb.pop_front();
    prev = e;
    checks++;
    if (obs !== e) begin
      failures++; $display("FAIL prio_load2 obs=%h exp=%h", obs, e);
    end
    // Stall with hazard: everything holds, hazard_stall stays asserted.
    @(negedge clk);
    drive(1'b1, C_ADD, 5'd3, 5'd9, 5'd4, 32'h0000_4014);
    st = 1'b1;
    #1;
    checks++;
    if (hazard_stall !== 1'b1) begin
      failures++; $display("FAIL prio_stall_hazard obs=%b exp=1", hazard_stall);
    end
    sb.push_back(prev);
    @(posedge clk); #1;
    e = sb.pop_front();
    checks++;
    if (obs !== e) begin
      failures++; $display("FAIL prio_stall_hold obs=%h exp=%h", obs, e);
    end
    checks++;
    if (hazard_stall !== 1'b1) begin
      failures++; $display("FAIL prio_stall_hazard_held obs=%b exp=1", hazard_stall);
    end
    @(negedge clk);
    st = 1'b0;
    sb.push_back(mk(1'b0, 10'h000, 5'd3, 5'd9, 5'd4, 32'h0000_4014, 2'd2));
    @(posedge clk); #1;
    e = sb.pop_front();
    checks++;
    if (obs !== e) begin
      failures++; $display("FAIL prio_release_bubble obs=%h exp=%h", obs, e);
    end
    sb.push_back(mk(1'b1, C_ADD, 5'd3, 5'd9, 5'd4, 32'h0000_4014, 2'd2));
    @(posedge clk); #1;
    e = sb.pop_front();
    checks++;
    if (obs !== e) begin
      failures++; $display("FAIL prio_release_issue obs=%h exp=%h", obs, e);
    end
  endtask

  task automatic test_saturation();
    logic [1:0] exp_cnt[5];
    logic [1:0] cur;
    exp_cnt = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++;
    if (bubble_cnt !== 2'd0) begin
      failures++; $display("FAIL sat_reset obs=%0d exp=0", bubble_cnt);
    end
    @(negedge clk);
    rst_n = 1'b1;
    cur = 2'd0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      drive(1'b1, C_LOAD, 5'd1, 5'd5, 5'd0, 32'h0000_5000 + 32'(i * 16));
      sb.push_back(mk(1'b1, C_LOAD, 5'd1, 5'd5, 5'd0, 32'h0000_5000 + 32'(i * 16), cur));
      @(posedge clk); #1;
      e = sb.pop_front();
      checks++;
      if (obs !== e) begin
        failures++; $display("FAIL sat_load%0d obs=%h exp=%h", i, obs, e);
      end
      @(negedge clk);
      drive(1'b1, C_ADD, 5'd5, 5'd2, 5'd6, 32'h0000_5004 + 32'(i * 16));
      cur = exp_cnt[i];
      sb.push_back(mk(1'b0, 10'h000, 5'd5, 5'd2, 5'd6, 32'h0000_5004 + 32'(i * 16), cur));
      @(posedge clk); #1;
      e = sb.pop_front();
      checks++;
      if (obs !== e) begin
        failures++; $display("FAIL sat_bubble%0d obs=%h exp=%h cnt=%0d", i, obs, e, bubble_cnt);
      end
    end
  endtask

  initial begin
    test_reset();
    test_transfer();
    test_load_use();
    test_zero_reg();
    test_priority();
    test_saturation();
    checks++;
    if (sb.size() != 0) begin
      failures++; $display("FAIL scoreboard_drain obs=%0d exp=0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
